pipe_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RV32 pipeline. It drives the hold (`stall_*`) and bubble (`flush_*`) controls of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, branch/jump redirects, instruction- and data-memory wait states, and fence draining. Inter-stage registers only implement the controls; every sequencing decision is made here.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_ctrl_hazard_detect.sv | 21 ++
 rtl/pipe_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// The optional performance counters are enabled by PIPE_CTRL_PERF_EN.
package pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [31:0] NOP   = 32'h0000_0033;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparison between the EX load and the ID source operands.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    output logic             load_use
);

    // x0 never carries a real dependency
    always_comb begin
        load_use = ex_mem_read && (ex_rd != '0) &&
                   ((id_use_rs1 && (ex_rd == id_rs1)) ||
                    (id_use_rs2 && (ex_rd == id_rs2)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Optional feature macro: PIPE_CTRL_PERF_EN adds stall/flush perf counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_fence,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             pc_redirect,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             stall_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             flush_mem_wb
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

    localparam int unsigned DCNT_W = $clog2(DRAIN_CYCLES + 1);

    state_t              state, state_n, ret, ret_n, eff;
    logic [DCNT_W-1:0]   dcnt, dcnt_n;
    logic                drop, drop_n;
    logic                load_use;
    logic                dwait;
    logic                redir;
    logic                drain_bubble;

    hazard_detect u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    // DWAIT behaves as the suspended state once the data access completes
    assign eff          = (state == DWAIT) ? ret : state;
    assign dwait        = dmem_req && !dmem_ready;
    assign redir        = ex_redirect && !dwait;
    assign drain_bubble = ((eff == DRAIN) && (dcnt > DCNT_W'(1))) ||
                          ((eff == RUN) && id_fence);

    // State, suspended state, drain counter and wrong-path flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            ret   <= RUN;
            dcnt  <= '0;
            drop  <= 1'b0;
        end else begin
            state <= state_n;
            ret   <= ret_n;
            dcnt  <= dcnt_n;
            drop  <= drop_n;
        end
    end

    // Next-state decision in priority order: dmem wait, redirect, drain, rest
    always_comb begin
        state_n = eff;
        ret_n   = eff;
        dcnt_n  = dcnt;
        drop_n  = drop;
        if (dwait) begin
            state_n = DWAIT;
        end else if (redir) begin
            state_n = RUN;
            dcnt_n  = '0;
            drop_n  = drop || !imem_ready;
        end else if ((eff == DRAIN) && (dcnt > DCNT_W'(1))) begin
            dcnt_n = dcnt - DCNT_W'(1);
        end else if ((eff == RUN) && id_fence) begin
            state_n = DRAIN;
            dcnt_n  = DCNT_W'(DRAIN_CYCLES);
        end else begin
            // last drain step lets the fence advance; otherwise normal flow
            state_n = RUN;
            dcnt_n  = '0;
            if (!load_use && imem_ready && drop) begin
                drop_n = 1'b0;
            end
        end
    end

    // Pipeline controls; a stalled register never sees a flush
    always_comb begin
        pc_stall     = 1'b0;
        pc_redirect  = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        stall_mem_wb = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;
        if (dwait) begin
            pc_stall     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end else if (redir) begin
            pc_redirect = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (drain_bubble || load_use) begin
            pc_stall    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (!imem_ready) begin
            pc_stall    = 1'b1;
            flush_if_id = 1'b1;
        end else if (drop) begin
            flush_if_id = 1'b1;
        end
        flush_if_id  = flush_if_id  && !stall_if_id;
        flush_id_ex  = flush_id_ex  && !stall_id_ex;
        flush_ex_mem = flush_ex_mem && !stall_ex_mem;
        flush_mem_wb = flush_mem_wb && !stall_mem_wb;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic any_flush;
    assign any_flush = flush_if_id || flush_id_ex || flush_ex_mem || flush_mem_wb;

    // Free-running stall and flush cycle counters, wrapping at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pc_stall) begin
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            end
            if (any_flush) begin
                perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// against a cycle-level behavioural model of the hazard rules.
module tb_pipe_ctrl;

    localparam int unsigned DC = 3;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, id_fence, ex_mem_read, ex_redirect;
    logic       imem_ready, dmem_req, dmem_ready;
    logic       pc_stall, pc_redirect;
    logic       stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic       flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int          tests;
    int          fails;
    int unsigned owed;
    bit          draining;
    bit          drop_m;
    int unsigned stall_cnt_m;
    int unsigned flush_cnt_m;

    pipe_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_fence     (id_fence),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_redirect  (ex_redirect),
        .imem_ready   (imem_ready),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_stall     (pc_stall),
        .pc_redirect  (pc_redirect),
        .stall_if_id  (stall_if_id),
        .stall_id_ex  (stall_id_ex),
        .stall_ex_mem (stall_ex_mem),
        .stall_mem_wb (stall_mem_wb),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_ex_mem (flush_ex_mem),
        .flush_mem_wb (flush_mem_wb)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] observed();
        return {pc_stall, pc_redirect, stall_if_id, stall_id_ex, stall_ex_mem,
                stall_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};
    endfunction

    task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic fence, input logic [4:0] rd,
                         input logic mr, input logic redirect, input logic iready,
                         input logic dreq, input logic dready);
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_fence = fence; ex_rd = rd; ex_mem_read = mr; ex_redirect = redirect;
        imem_ready = iready; dmem_req = dreq; dmem_ready = dready;
    endtask

    task automatic idle();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic model_reset();
        owed = 0; draining = 1'b0; drop_m = 1'b0;
        stall_cnt_m = 0; flush_cnt_m = 0;
    endtask

    // Expected controls for this cycle; advances the model by one clock
    task automatic model_step(output logic [9:0] e);
        logic ps, pr, s_ifid, s_idex, s_exmem, f_ifid, f_idex, f_memwb;
        logic dw, lu, bubble;
        ps = 0; pr = 0; s_ifid = 0; s_idex = 0; s_exmem = 0;
        f_ifid = 0; f_idex = 0; f_memwb = 0; bubble = 0;
        dw = dmem_req && !dmem_ready;
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        if (dw) begin
            ps = 1; s_ifid = 1; s_idex = 1; s_exmem = 1; f_memwb = 1;
        end else if (ex_redirect) begin
            pr = 1; f_ifid = 1; f_idex = 1;
            if (!imem_ready) drop_m = 1'b1;
            draining = 1'b0; owed = 0;
        end else if (draining && owed > 0) begin
            bubble = 1; owed = owed - 1;
        end else if (!draining && id_fence) begin
            bubble = 1; draining = 1'b1; owed = DC - 1;
        end else begin
            draining = 1'b0;
            if (lu) bubble = 1;
            else if (!imem_ready) begin ps = 1; f_ifid = 1; end
            else if (drop_m) begin f_ifid = 1; drop_m = 1'b0; end
        end
        if (bubble) begin ps = 1; s_ifid = 1; f_idex = 1; end
        e = {ps, pr, s_ifid, s_idex, s_exmem, 1'b0, f_ifid, f_idex, 1'b0, f_memwb};
        if (ps) stall_cnt_m = stall_cnt_m + 1;
        if (f_ifid || f_idex || f_memwb) flush_cnt_m = flush_cnt_m + 1;
    endtask

    // Check the current cycle's controls, then move to the next cycle
    task automatic cyc(input string tag);
        logic [9:0] exp_v, obs_v;
        #1;
        model_step(exp_v);
        obs_v = observed();
        tests++;
        assert (obs_v === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs_v, exp_v);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        logic [9:0] obs_v;
        obs_v = observed();
        tests++;
        assert (obs_v === 10'b0) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs_v, 10'b0);
        end
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic check_perf(input string tag);
        tests++;
        assert (perf_stall_cnt === 32'(stall_cnt_m)) else begin
            fails++;
            $error("FAIL %s_stall observed=%0d expected=%0d", tag, perf_stall_cnt, stall_cnt_m);
        end
        tests++;
        assert (perf_flush_cnt === 32'(flush_cnt_m)) else begin
            fails++;
            $error("FAIL %s_flush observed=%0d expected=%0d", tag, perf_flush_cnt, flush_cnt_m);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        rst = 1'b1;
        idle();
        #1;
        check_zero("reset_idle");
        @(negedge clk);
        rst = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
        check_perf("perf_reset");
`endif

        // load-use on rs1, then released; x0 destination never stalls
        drive(5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("lu_stall");
        drive(5'd6, 1'b1, 5'd1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("lu_release");
        drive(5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("lu_x0");
        drive(5'd3, 1'b0, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("lu_rs2");

        // redirect overrides a simultaneous load-use
        drive(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("redir_over_lu");
        idle();
        cyc("redir_after");

        // dmem wait freezes a pending redirect for 3 cycles
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            cyc("dwait_redir_hold");
        end
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc("dwait_redir_fire");

        // redirect during fetch miss: wrong-path response is dropped
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("redir_imiss");
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("imem_wait");
        idle();
        cyc("drop_flush");
        cyc("drop_cleared");

        // fence drain with a dmem miss inserted between bubbles
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("fence_b1");
        cyc("fence_b2");
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("fence_dwait1");
        cyc("fence_dwait2");
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc("fence_b3");
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("fence_advance");
        idle();
        cyc("fence_done");

        // redirect aborts a drain in progress
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("abort_b1");
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("abort_redir");
        idle();
        cyc("abort_after");

        // asynchronous reset mid-drain, released before any clock edge
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("pre_rst_fence");
        idle();
        rst = 1'b1;
        #1;
        check_zero("rst_mid_drain");
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        cyc("post_rst_run");

        // pending drop does not survive reset
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("pre_rst_drop");
        idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        cyc("post_rst_nodrop");

        // randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            drive(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) == 0), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)));
            cyc("random");
        end
`ifdef PIPE_CTRL_PERF_EN
        check_perf("perf_final");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
